// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared constants and types for the register-file writeback arbiter.
// Holds the values the arbiter shares with the register file: the hardwired
// zero register address, the active write-enable level and the default
// buffer depth. Also holds the buffered-entry record, the grant-source enum
// and a helper that turns a destination address into a busy-mask bit.
// No ports (package).
// ---------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  // Register 0 is hardwired to zero, so writes to it are dropped.
  localparam logic [RF_ADDR_W-1:0] RF_ADDR_ZERO = 5'd0;

  // Level of the register file write enable that performs a write.
  localparam logic RF_WRITE_ENABLED = 1'b1;

  // Number of port-1 writebacks buffered when no depth is given.
  localparam int RF_ARB_DEPTH_DEFAULT = 2;

  // One buffered writeback: destination, value and originating PC.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
    logic [RF_DATA_W-1:0] pc;
  } wb_entry_t;

  // Which source owns the register file write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB0  = 2'd1,
    GRANT_HEAD = 2'd2,
    GRANT_WB1  = 2'd3
  } grant_t;

  // One-hot busy bit for a destination; register 0 is never reported busy.
  function automatic logic [31:0] addr_onehot(input logic [RF_ADDR_W-1:0] addr);
    logic [31:0] mask;
    mask    = 32'h1 << addr;
    mask[0] = 1'b0;
    return mask;
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// ---------------------------------------------------------------------------
// rf_arb_fifo
// In-order buffer for MDU (port-1) writebacks. DEPTH entries, power of two,
// so the read/write pointers wrap naturally modulo DEPTH. Each slot carries
// a valid bit so the owner can build a busy mask from live entries.
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   push          write push_entry at the tail (ignored when full)
//   push_entry    {addr, data, pc} to enqueue
//   pop           drop the head entry (ignored when empty)
//   head          entry at the read pointer
//   count         current occupancy, 0..DEPTH
//   entry_valid   per-slot valid flags
//   entry_addr    per-slot destination addresses
// ---------------------------------------------------------------------------
module rf_arb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = RF_ARB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  wb_entry_t                       push_entry,
  input  logic                            pop,
  output wb_entry_t                       head,
  output logic [CNT_W-1:0]                count,
  output logic [DEPTH-1:0]                entry_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0] entry_addr
);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  // Guard against overflow/underflow so a misbehaving owner cannot corrupt
  // the pointers.
  assign push_ok = push && (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Pointer, occupancy and slot-valid state. A pop and push never touch the
  // same slot in one cycle because that needs the buffer both empty and full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (pop_ok) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        valid_q[rd_ptr] <= 1'b0;
      end
      if (push_ok) begin
        wr_ptr          <= wr_ptr + PTR_W'(1);
        valid_q[wr_ptr] <= 1'b1;
      end
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Payload storage needs no reset; stale slots are masked by valid_q.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = mem[i].addr;
    end
  end

  assign head        = mem[rd_ptr];
  assign count       = count_q;
  assign entry_valid = valid_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single write port between the pipeline
// writeback (port 0, zero latency) and the multi-cycle unit writeback
// (port 1, buffered in order). A full buffer takes priority so it always
// drains; otherwise the pipeline wins and the buffer fills idle cycles.
// Writes to register 0 are accepted and silently dropped on both ports.
//
// Optional feature: define RF_ARB_BYPASS_EN to let a port-1 writeback go
// straight to the register file when the buffer is empty and port 0 is idle.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   wb0_valid/ready, addr/data/pc    pipeline writeback handshake and payload
//   wb1_valid/ready, addr/data/pc    MDU writeback handshake and payload
//   rf_write_enable/addr/data        register file write port
//   rf_curr_pc                       PC of the write being performed
//   busy_mask                        bit n set while a write to rn is buffered
//   buf_count                        current buffer occupancy
// ---------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = RF_ARB_DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb0_valid,
  output logic                 wb0_ready,
  input  logic [RF_ADDR_W-1:0] wb0_addr,
  input  logic [RF_DATA_W-1:0] wb0_data,
  input  logic [RF_DATA_W-1:0] wb0_pc,
  input  logic                 wb1_valid,
  output logic                 wb1_ready,
  input  logic [RF_ADDR_W-1:0] wb1_addr,
  input  logic [RF_DATA_W-1:0] wb1_data,
  input  logic [RF_DATA_W-1:0] wb1_pc,
  output logic                 rf_write_enable,
  output logic [RF_ADDR_W-1:0] rf_write_addr,
  output logic [RF_DATA_W-1:0] rf_write_data,
  output logic [RF_DATA_W-1:0] rf_curr_pc,
  output logic [31:0]          busy_mask,
  output logic [CNT_W-1:0]     buf_count
);

  wb_entry_t                       head;
  wb_entry_t                       push_entry;
  logic [CNT_W-1:0]                fifo_count;
  logic [DEPTH-1:0]                entry_valid;
  logic [DEPTH-1:0][RF_ADDR_W-1:0] entry_addr;
  logic                            full;
  logic                            wb0_live;
  logic                            wb1_live;
  logic                            push;
  logic                            pop;
  grant_t                          grant;

  // Readiness depends only on the registered count, so a full buffer never
  // lets a port-1 write slip through in the same cycle.
  assign full      = (fifo_count == CNT_W'(DEPTH));
  assign wb0_ready = ~full;
  assign wb1_ready = ~full;

  // A "live" transfer is one that completed the handshake and targets a
  // real register; transfers to r0 are consumed with no further effect.
  assign wb0_live = wb0_valid && wb0_ready && (wb0_addr != RF_ADDR_ZERO);
  assign wb1_live = wb1_valid && wb1_ready && (wb1_addr != RF_ADDR_ZERO);

  // Write-port priority: a full buffer drains first, then the pipeline, then
  // any buffered entry, then (optionally) a direct port-1 bypass. A pipeline
  // write to r0 still owns the cycle, it just writes nothing.
  always_comb begin
    grant = GRANT_NONE;
    if (full) begin
      grant = GRANT_HEAD;
    end else if (wb0_valid) begin
      grant = wb0_live ? GRANT_WB0 : GRANT_NONE;
    end else if (fifo_count != '0) begin
      grant = GRANT_HEAD;
`ifdef RF_ARB_BYPASS_EN
    end else if (wb1_live) begin
      grant = GRANT_WB1;
`endif
    end
  end

  // A bypassed port-1 write goes to the register file instead of the buffer.
  assign push       = wb1_live && (grant != GRANT_WB1);
  assign pop        = (grant == GRANT_HEAD);
  assign push_entry = '{addr: wb1_addr, data: wb1_data, pc: wb1_pc};

  // Steer the granted source onto the write port; idle outputs read zero.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    rf_curr_pc      = '0;
    case (grant)
      GRANT_WB0: begin
        rf_write_enable = RF_WRITE_ENABLED;
        rf_write_addr   = wb0_addr;
        rf_write_data   = wb0_data;
        rf_curr_pc      = wb0_pc;
      end
      GRANT_HEAD: begin
        rf_write_enable = RF_WRITE_ENABLED;
        rf_write_addr   = head.addr;
        rf_write_data   = head.data;
        rf_curr_pc      = head.pc;
      end
      GRANT_WB1: begin
        rf_write_enable = RF_WRITE_ENABLED;
        rf_write_addr   = wb1_addr;
        rf_write_data   = wb1_data;
        rf_curr_pc      = wb1_pc;
      end
      default: begin
        rf_write_enable = 1'b0;
      end
    endcase
  end

  // Every live buffer slot marks its destination busy so the issuer can hold
  // back a younger pipeline write to the same register.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        busy_mask = busy_mask | addr_onehot(entry_addr[i]);
      end
    end
  end

  assign buf_count = fifo_count;

  rf_arb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .entry_valid(entry_valid),
    .entry_addr (entry_addr)
  );

endmodule
